fb_line_writer: RTL and testbench

Parametrised framebuffer line loader between the UART line receiver and the single-port display RAM. It accepts one complete pixel line (row index plus packed pixels) over a valid/ready handshake and serialises it into the RAM write port, one pixel per cycle. Writes stall whenever the display side claims the RAM. Optional multi-bank (double-buffered) frames swap the displayed bank when the last row of a frame has been written. Pixel width, line width, frame height and bank count are parameters.

---
 rtl/fb_line_writer_if.sv | 38 +++
 rtl/fb_line_writer.sv | 135 +++++++++++++
 tb/tb_fb_line_writer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/fb_line_writer_if.sv
// Line-descriptor handshake, display-RAM write port and status flags of the
// framebuffer line writer, bundled so both ends share one width derivation.
interface fb_line_writer_if #(
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480,
  parameter int BPP       = 3,
  parameter int NUM_BANKS = 1
);
  localparam int ROW_W  = $clog2(HEIGHT);
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int ADDR_W = $clog2(NUM_BANKS * WIDTH * HEIGHT);

  logic                   line_valid;
  logic                   line_ready;
  logic [ROW_W-1:0]       line_row;
  logic [WIDTH*BPP-1:0]   line_data;
  logic                   rd_busy;
  logic                   wr_en;
  logic [ADDR_W-1:0]      wr_addr;
  logic [BPP-1:0]         wr_data;
  logic [BANK_W-1:0]      disp_bank;
  logic                   line_done;
  logic                   frame_done;
  logic                   line_err;
  logic                   busy;

  modport slave (
    input  line_valid, line_row, line_data, rd_busy,
    output line_ready, wr_en, wr_addr, wr_data, disp_bank,
           line_done, frame_done, line_err, busy
  );

  modport master (
    output line_valid, line_row, line_data, rd_busy,
    input  line_ready, wr_en, wr_addr, wr_data, disp_bank,
           line_done, frame_done, line_err, busy
  );
endinterface

// File: rtl/fb_line_writer.sv
// Accepts one packed pixel line and streams it into the display RAM one pixel
// per cycle, yielding to the display reader and swapping banks per frame.
module fb_line_writer #(
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480,
  parameter int BPP       = 3,
  parameter int NUM_BANKS = 1
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  fb_line_writer_if.slave   bus
);
  localparam int ROW_W  = $clog2(HEIGHT);
  localparam int COL_W  = $clog2(WIDTH);
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int ADDR_W = $clog2(NUM_BANKS * WIDTH * HEIGHT);

  localparam logic [ADDR_W-1:0] BANK_WORDS = ADDR_W'(WIDTH * HEIGHT);
  localparam logic [ADDR_W-1:0] LINE_WORDS = ADDR_W'(WIDTH);
  localparam logic [ROW_W:0]    ROW_LIMIT  = (ROW_W+1)'(HEIGHT);
  localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(WIDTH - 1);
  localparam logic [BANK_W-1:0] BANK_LAST  = BANK_W'(NUM_BANKS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_e;

  state_e               state_q;
  logic [COL_W-1:0]     col_q;
  logic [ROW_W-1:0]     row_q;
  logic [BANK_W-1:0]    disp_bank_q;
  logic [WIDTH*BPP-1:0] line_q;
  logic                 line_done_q;
  logic                 frame_done_q;
  logic                 line_err_q;
  logic [BANK_W-1:0]    wbank_d;

  logic accept;
  logic row_ok;
  logic col_last;

  assign bus.line_ready = (state_q == S_IDLE) && rst_n;
  assign accept         = bus.line_ready && bus.line_valid;
  assign row_ok         = {1'b0, bus.line_row} < ROW_LIMIT;
  assign col_last       = (col_q == COL_LAST);

  // The bank being filled is always the one after the displayed bank.
  always_comb begin
    wbank_d = '0;
    if (NUM_BANKS > 1 && disp_bank_q != BANK_LAST) begin
      wbank_d = disp_bank_q + 1'b1;
    end
  end

  // NOTE: the line buffer is pure datapath, loaded only on accept and never
  // read outside WRITE, so it carries no reset.
  always_ff @(posedge clk_sys) begin
    if (accept) begin
      line_q <= bus.line_data;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      disp_bank_q  <= '0;
      line_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      line_err_q   <= 1'b0;
    end else begin
      line_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      line_err_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.line_valid) begin
            row_q <= bus.line_row;
            col_q <= '0;
            if (row_ok) begin
              state_q <= S_WRITE;
            end else begin
              state_q    <= S_ERR;
              line_err_q <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (!bus.rd_busy) begin
            if (col_last) begin
              col_q        <= '0;
              state_q      <= S_DONE;
              line_done_q  <= 1'b1;
              frame_done_q <= (row_q == ROW_LAST);
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (frame_done_q) begin
            disp_bank_q <= wbank_d;
          end
          state_q <= S_IDLE;
        end
        S_ERR: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // A stalled write keeps col_q, so address and data hold through rd_busy.
  assign bus.wr_en      = (state_q == S_WRITE) && !bus.rd_busy;
  assign bus.wr_addr    = ADDR_W'(wbank_d) * BANK_WORDS
                        + ADDR_W'(row_q) * LINE_WORDS
                        + ADDR_W'(col_q);
  assign bus.wr_data    = line_q[int'(col_q)*BPP +: BPP];
  assign bus.disp_bank  = disp_bank_q;
  assign bus.line_done  = line_done_q;
  assign bus.frame_done = frame_done_q;
  assign bus.line_err   = line_err_q;
  assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_fb_line_writer.sv
// Directed and randomized line loads against a write-list model of the
// framebuffer writer, with two banks and a non-power-of-two frame height.
module tb_fb_line_writer;
  localparam int W  = 8;
  localparam int H  = 5;
  localparam int B  = 3;
  localparam int NB = 2;
  localparam int LW = W * B;
  localparam int RW = $clog2(H);

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   model_disp;

  fb_line_writer_if #(.WIDTH(W), .HEIGHT(H), .BPP(B), .NUM_BANKS(NB)) bus ();

  fb_line_writer #(.WIDTH(W), .HEIGHT(H), .BPP(B), .NUM_BANKS(NB)) dut (
    .clk_sys (clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "time limit expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, drive rd_busy for the new cycle, settle before sampling.
  task automatic cycle(input bit b);
    @(posedge clk);
    #1;
    bus.rd_busy = b;
    #1;
  endtask

  task automatic set_desc(input int row, input logic [LW-1:0] data);
    bus.line_valid = 1'b1;
    bus.line_row   = RW'(row);
    bus.line_data  = data;
  endtask

  task automatic present(input int row, input logic [LW-1:0] data);
    set_desc(row, data);
    check("ready_before_accept", bus.line_ready, 1);
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] d;
    for (int i = 0; i < LW; i++) d[i] = 1'($urandom_range(0, 1));
    return d;
  endfunction

  // Precondition: current cycle is a ready cycle with (row, data) presented.
  // mode 0: no stalls, 1: random stalls, 2: stall on 3rd and 4th write cycles.
  task automatic do_line(input int row, input logic [LW-1:0] data, input int mode,
                         input bit hold, input int nrow, input logic [LW-1:0] ndata);
    int  wb;
    int  base;
    int  n;
    int  k;
    bit  b;
    if (row >= H) begin
      cycle(1'($urandom_range(0, 1)));
      if (hold) set_desc(nrow, ndata);
      else begin bus.line_valid = 1'b0; bus.line_data = rand_line(); end
      check("err_pulse",    bus.line_err,   1);
      check("err_no_write", bus.wr_en,      0);
      check("err_busy",     bus.busy,       1);
      check("err_ready",    bus.line_ready, 0);
      check("err_no_done",  bus.line_done,  0);
      cycle(1'($urandom_range(0, 1)));
      check("err_pulse_end", bus.line_err,   0);
      check("err_ready_ret", bus.line_ready, 1);
      check("err_bank",      bus.disp_bank,  64'(model_disp));
      return;
    end
    wb   = (model_disp + 1) % NB;
    base = wb * W * H + row * W;
    n = 0;
    k = 0;
    while (n < W) begin
      if (mode == 0)      b = 1'b0;
      else if (mode == 2) b = (k == 2 || k == 3);
      else                b = (k < 4 * W) && ($urandom_range(0, 3) == 0);
      cycle(b);
      if (k == 0) begin
        if (hold) set_desc(nrow, ndata);
        else begin bus.line_valid = 1'b0; bus.line_data = rand_line(); end
      end
      check("wr_en",   bus.wr_en,      64'(!b));
      check("wr_addr", bus.wr_addr,    64'(base + n));
      if (!b) check("wr_data", bus.wr_data, 64'(data[n*B +: B]));
      check("write_no_done", bus.line_done, 0);
      check("write_ready",   bus.line_ready, 0);
      if (!b) n++;
      k++;
    end
    cycle(1'($urandom_range(0, 1)));
    check("line_done",  bus.line_done,  1);
    check("frame_done", bus.frame_done, 64'(row == H - 1));
    check("done_no_wr", bus.wr_en,      0);
    check("done_busy",  bus.busy,       1);
    if (row == H - 1) model_disp = wb;
    cycle(1'($urandom_range(0, 1)));
    check("ready_return",  bus.line_ready, 1);
    check("done_pulse_end", bus.line_done, 0);
    check("frame_pulse_end", bus.frame_done, 0);
    check("disp_bank",     bus.disp_bank,  64'(model_disp));
    check("idle_not_busy", bus.busy,       0);
  endtask

  initial begin
    logic [LW-1:0] d;
    logic [LW-1:0] frame_d [H];
    int            row;
    n_checks       = 0;
    n_fail         = 0;
    model_disp     = 0;
    rst_n          = 1'b0;
    bus.line_valid = 1'b0;
    bus.line_row   = '0;
    bus.line_data  = '0;
    bus.rd_busy    = 1'b0;

    // Reset state.
    cycle(0);
    cycle(0);
    check("rst_ready",  bus.line_ready, 0);
    check("rst_wr_en",  bus.wr_en,      0);
    check("rst_busy",   bus.busy,       0);
    check("rst_bank",   bus.disp_bank,  0);
    check("rst_done",   bus.line_done,  0);
    check("rst_frame",  bus.frame_done, 0);
    check("rst_err",    bus.line_err,   0);
    rst_n = 1'b1;
    #1;

    // Row 2, pixels 0..7, no stalls.
    for (int i = 0; i < W; i++) d[i*B +: B] = B'(i);
    present(2, d);
    do_line(2, d, 0, 0, 0, '0);

    // Same line, display claims the RAM on the 3rd and 4th write cycles.
    present(2, d);
    do_line(2, d, 2, 0, 0, '0);

    // Out-of-range rows are discarded.
    present(5, rand_line());
    do_line(5, '0, 0, 0, 0, '0);
    present(7, rand_line());
    do_line(7, '0, 0, 0, 0, '0);

    // Full frame with line_valid held high back-to-back.
    for (int r = 0; r < H; r++) frame_d[r] = rand_line();
    present(0, frame_d[0]);
    for (int r = 0; r < H; r++) begin
      if (r < H - 1) do_line(r, frame_d[r], 1, 1, r + 1, frame_d[r+1]);
      else           do_line(r, frame_d[r], 1, 0, 0, '0);
    end
    check("frame_swapped", bus.disp_bank, 1);
    d = rand_line();
    present(0, d);
    do_line(0, d, 0, 0, 0, '0);

    // Reset in the middle of the 5th write while bank 1 is displayed.
    d = rand_line();
    present(1, d);
    for (int k = 0; k < 5; k++) begin
      cycle(0);
      if (k == 0) bus.line_valid = 1'b0;
      check("pre_rst_wr_en", bus.wr_en,   1);
      check("pre_rst_addr",  bus.wr_addr, 64'(W + k));
    end
    rst_n = 1'b0;
    #1;
    check("rst_ready_drop", bus.line_ready, 0);
    cycle(0);
    rst_n = 1'b1;
    #1;
    model_disp = 0;
    check("post_rst_wr_en", bus.wr_en,      0);
    check("post_rst_busy",  bus.busy,       0);
    check("post_rst_bank",  bus.disp_bank,  0);
    check("post_rst_ready", bus.line_ready, 1);
    d = rand_line();
    present(3, d);
    do_line(3, d, 1, 0, 0, '0);

    // Random rows (some out of range) with random stalls.
    for (int i = 0; i < 10; i++) begin
      row = $urandom_range(0, (1 << RW) - 1);
      d   = rand_line();
      present(row, d);
      do_line(row, d, 1, 0, 0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
